// File: rtl/gray_sobel_3x3_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | gray_sobel_3x3_if : gray pixel stream in, edge magnitude stream out       |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
interface gray_sobel_3x3_if;
    logic [7:0]  iGray;
    logic        iDval;
    logic [15:0] iX_Cont;
    logic [15:0] iY_Cont;
    logic [7:0]  oEdge;
    logic        oEdgeBit;
    logic [15:0] oX_Cont;
    logic [15:0] oY_Cont;
    logic        oDval;

    modport master (
        output iGray, iDval, iX_Cont, iY_Cont,
        input  oEdge, oEdgeBit, oX_Cont, oY_Cont, oDval
    );

    modport slave (
        input  iGray, iDval, iX_Cont, iY_Cont,
        output oEdge, oEdgeBit, oX_Cont, oY_Cont, oDval
    );
endinterface
`default_nettype wire

// File: rtl/gray_sobel_3x3.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | gray_sobel_3x3 : streaming 3x3 Sobel |Gx|+|Gy| with threshold bit         |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module gray_sobel_3x3 #(
    parameter int IMG_WIDTH = 640,
    parameter int THRESH    = 64
) (
    input  wire logic       iCLK,
    input  wire logic       iReset,
    gray_sobel_3x3_if.slave pix
);
    localparam int          c_AW     = (IMG_WIDTH > 1) ? $clog2(IMG_WIDTH) : 1;
    localparam logic [15:0] c_WIDTH  = 16'(IMG_WIDTH);
    localparam logic [7:0]  c_THRESH = 8'(THRESH);

    // Line buffers: lb1 holds row y-1, lb0 holds row y-2 (not reset)
    logic [7:0] lb0_mem [IMG_WIDTH];
    logic [7:0] lb1_mem [IMG_WIDTH];

    logic            in_range;
    logic [c_AW-1:0] addr;
    logic [7:0]      lb0_rd;
    logic [7:0]      lb1_rd;
    logic            border;

    always_comb begin
        in_range = (pix.iX_Cont < c_WIDTH);
        addr     = pix.iX_Cont[c_AW-1:0];
        lb0_rd   = '0;
        lb1_rd   = '0;
        if (in_range) begin
            lb0_rd = lb0_mem[addr];
            lb1_rd = lb1_mem[addr];
        end
        border = (pix.iX_Cont < 16'd2) || (pix.iY_Cont < 16'd2) || !in_range;
    end

    always_ff @(posedge iCLK) begin
        if (pix.iDval && in_range) begin
            lb0_mem[addr] <= lb1_rd;
            lb1_mem[addr] <= pix.iGray;
        end
    end

    // Window [row][col]: row 0 = top, col 0 = oldest column
    logic [7:0]  win_q [3][3];
    logic        v1_q, v2_q, dval_q;
    logic        mask1_q, mask2_q;
    logic [15:0] x1_q, y1_q, x2_q, y2_q, ox_q, oy_q;
    logic [11:0] mag2_q;
    logic [7:0]  edge_q;
    logic        bit_q;

    function automatic logic signed [11:0] ext(input logic [7:0] p);
        return $signed({4'b0000, p});
    endfunction

    logic signed [11:0] gx, gy;
    logic [11:0]        abs_gx, abs_gy, mag_d;
    logic [7:0]         sat, edge_d;
    logic               bit_d;

    always_comb begin
        gx = (ext(win_q[0][2]) + (ext(win_q[1][2]) <<< 1) + ext(win_q[2][2]))
           - (ext(win_q[0][0]) + (ext(win_q[1][0]) <<< 1) + ext(win_q[2][0]));
        gy = (ext(win_q[2][0]) + (ext(win_q[2][1]) <<< 1) + ext(win_q[2][2]))
           - (ext(win_q[0][0]) + (ext(win_q[0][1]) <<< 1) + ext(win_q[0][2]));
        abs_gx = gx[11] ? $unsigned(-gx) : $unsigned(gx);
        abs_gy = gy[11] ? $unsigned(-gy) : $unsigned(gy);
        mag_d  = abs_gx + abs_gy;
        sat    = (|mag2_q[11:8]) ? 8'hFF : mag2_q[7:0];
        edge_d = mask2_q ? 8'h00 : sat;
        bit_d  = !mask2_q && (sat >= c_THRESH);
    end

    always_ff @(posedge iCLK) begin
        if (iReset) begin
            for (int r = 0; r < 3; r++) begin
                for (int c = 0; c < 3; c++) begin
                    win_q[r][c] <= '0;
                end
            end
            v1_q    <= 1'b0;
            v2_q    <= 1'b0;
            dval_q  <= 1'b0;
            mask1_q <= 1'b0;
            mask2_q <= 1'b0;
            x1_q    <= '0;
            y1_q    <= '0;
            x2_q    <= '0;
            y2_q    <= '0;
            ox_q    <= '0;
            oy_q    <= '0;
            mag2_q  <= '0;
            edge_q  <= '0;
            bit_q   <= 1'b0;
        end else begin
            // Gaps freeze the window so results do not depend on idle cycles
            if (pix.iDval) begin
                for (int r = 0; r < 3; r++) begin
                    win_q[r][0] <= win_q[r][1];
                    win_q[r][1] <= win_q[r][2];
                end
                win_q[0][2] <= lb0_rd;
                win_q[1][2] <= lb1_rd;
                win_q[2][2] <= pix.iGray;
            end
            v1_q    <= pix.iDval;
            mask1_q <= border;
            x1_q    <= pix.iX_Cont;
            y1_q    <= pix.iY_Cont;

            v2_q    <= v1_q;
            mask2_q <= mask1_q;
            x2_q    <= x1_q;
            y2_q    <= y1_q;
            mag2_q  <= mag_d;

            dval_q  <= v2_q;
            ox_q    <= x2_q;
            oy_q    <= y2_q;
            edge_q  <= edge_d;
            bit_q   <= bit_d;
        end
    end

    assign pix.oEdge    = edge_q;
    assign pix.oEdgeBit = bit_q;
    assign pix.oX_Cont  = ox_q;
    assign pix.oY_Cont  = oy_q;
    assign pix.oDval    = dval_q;
endmodule
`default_nettype wire

// File: tb/tb_gray_sobel_3x3.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_gray_sobel_3x3 : randomized stimulus against an image-level model      |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module tb_gray_sobel_3x3;
    localparam int W = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_errors = 0;
    int   pulses = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc = cyc + 1;

    gray_sobel_3x3_if bus_a ();
    gray_sobel_3x3_if bus_b ();

    gray_sobel_3x3 #(.IMG_WIDTH(W), .THRESH(8)) dut_a (.iCLK(clk), .iReset(rst), .pix(bus_a.slave));
    gray_sobel_3x3 #(.IMG_WIDTH(W), .THRESH(9)) dut_b (.iCLK(clk), .iReset(rst), .pix(bus_b.slave));

    typedef struct {
        int x;
        int y;
        int mag;
        int bit_a;
        int bit_b;
        int cyc_in;
    } exp_t;

    exp_t q[$];
    exp_t mon_e;
    int   img [0:15][0:15];

    task automatic check(input string tag, input logic [31:0] got, input int exp);
        n_checks++;
        if (got !== 32'(exp)) begin
            n_errors++;
            $display("FAIL %s got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Sobel straight from the image: window bottom-right corner is (x,y)
    function automatic int ref_mag(input int x, input int y);
        int gxs = 0;
        int gys = 0;
        int p;
        for (int r = 0; r < 3; r++) begin
            for (int c = 0; c < 3; c++) begin
                p = img[y - 2 + r][x - 2 + c];
                gxs += p * (c - 1) * ((r == 1) ? 2 : 1);
                gys += p * (r - 1) * ((c == 1) ? 2 : 1);
            end
        end
        p = ((gxs < 0) ? -gxs : gxs) + ((gys < 0) ? -gys : gys);
        return (p > 255) ? 255 : p;
    endfunction

    task automatic set_bus(input int g, input int x, input int y, input bit v);
        bus_a.iGray = 8'(g);   bus_b.iGray = 8'(g);
        bus_a.iX_Cont = 16'(x); bus_b.iX_Cont = 16'(x);
        bus_a.iY_Cont = 16'(y); bus_b.iY_Cont = 16'(y);
        bus_a.iDval = v;       bus_b.iDval = v;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk); #1;
            bus_a.iDval = 1'b0;
            bus_b.iDval = 1'b0;
        end
    endtask

    task automatic drive_px(input int x, input int y);
        exp_t e;
        int   m;
        @(posedge clk); #1;
        set_bus(img[y][x], x, y, 1'b1);
        m = (x < 2 || y < 2 || x >= W) ? 0 : ref_mag(x, y);
        e.x = x; e.y = y; e.mag = m;
        e.bit_a = (x < 2 || y < 2 || x >= W) ? 0 : int'(m >= 8);
        e.bit_b = (x < 2 || y < 2 || x >= W) ? 0 : int'(m >= 9);
        e.cyc_in = cyc;
        q.push_back(e);
    endtask

    task automatic do_reset();
        exp_t keep[$];
        int   r;
        @(posedge clk); #1;
        bus_a.iDval = 1'b0; bus_b.iDval = 1'b0;
        rst = 1'b1;
        r = cyc;
        foreach (q[i]) if (q[i].cyc_in + 3 <= r) keep.push_back(q[i]);
        q = keep;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("rst_dval", {31'd0, bus_a.oDval}, 0);
        check("rst_edge", {24'd0, bus_a.oEdge}, 0);
        check("rst_bit", {31'd0, bus_a.oEdgeBit}, 0);
        check("rst_x", {16'd0, bus_a.oX_Cont}, 0);
        check("rst_y", {16'd0, bus_a.oY_Cont}, 0);
    endtask

    // mode: 0 flat, 1 vertical step, 2 horizontal step, 3 random, 4 random low-contrast
    task automatic send_frame(input int mode, input int h, input int extra,
                              input int maxgap, input int rst_row);
        for (int y = 0; y < h; y++) begin
            for (int x = 0; x < W + extra; x++) begin
                case (mode)
                    0:       img[y][x] = 100;
                    1:       img[y][x] = (x < 4) ? 0 : 200;
                    2:       img[y][x] = (y < 3) ? 10 : 12;
                    3:       img[y][x] = int'($urandom_range(255, 0));
                    default: img[y][x] = int'($urandom_range(40, 0));
                endcase
                if (x >= W) img[y][x] = int'($urandom_range(255, 0));
            end
        end
        for (int y = 0; y < h; y++) begin
            for (int x = 0; x < W + extra; x++) begin
                if (y == rst_row && x == 3) begin
                    do_reset();
                    return;
                end
                drive_px(x, y);
                idle(int'($urandom_range(maxgap, 0)));
            end
        end
    endtask

    always @(negedge clk) begin
        if (bus_a.oDval === 1'b1) pulses++;
        if (bus_a.oDval === 1'b1 || bus_b.oDval === 1'b1) begin
            if (q.size() == 0) begin
                check("unexpected_dval", 32'd1, 0);
            end else begin
                mon_e = q.pop_front();
                check("latency", cyc, mon_e.cyc_in + 3);
                check("dval_b", {31'd0, bus_b.oDval}, 1);
                check("x", {16'd0, bus_a.oX_Cont}, mon_e.x);
                check("y", {16'd0, bus_a.oY_Cont}, mon_e.y);
                check("edge", {24'd0, bus_a.oEdge}, mon_e.mag);
                check("edge_b", {24'd0, bus_b.oEdge}, mon_e.mag);
                check("bit_t8", {31'd0, bus_a.oEdgeBit}, mon_e.bit_a);
                check("bit_t9", {31'd0, bus_b.oEdgeBit}, mon_e.bit_b);
            end
        end
    end

    initial begin
        set_bus(0, 0, 0, 1'b0);
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("init_dval", {31'd0, bus_a.oDval}, 0);
        check("init_edge", {24'd0, bus_a.oEdge}, 0);
        @(posedge clk); #1;
        rst = 1'b0;

        // Flat frame: 32 results, all zero
        pulses = 0;
        send_frame(0, 4, 0, 0, -1);
        idle(6);
        check("flat_pulses", pulses, 32);

        send_frame(1, 5, 0, 0, -1);   // vertical step
        send_frame(2, 6, 0, 0, -1);   // horizontal step, threshold 8 vs 9
        send_frame(1, 5, 0, 3, -1);   // vertical step with random gaps
        idle(6);

        // Reset in row 2, then a fresh flat frame
        send_frame(3, 4, 0, 1, 2);
        send_frame(0, 4, 0, 1, -1);
        idle(6);

        // Out-of-range columns, then a normal frame
        send_frame(3, 4, 2, 1, -1);
        send_frame(3, 5, 0, 0, -1);

        for (int k = 0; k < 4; k++) send_frame((k % 2) ? 3 : 4, 6, k % 2, 3, -1);
        idle(10);
        check("queue_drained", q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
`default_nettype wire
